// File: rtl/rptr_handler_fwft.sv
// Read-side pointer and flag handler for a dual-clock FIFO, read clock domain.
// Tracks binary/Gray read pointers, derives flags and presents data first-word-fall-through.
module rptr_handler_fwft #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int AE_THRESH  = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [PTR_WIDTH:0]    g_wptr_sync_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  mem_rd_en_o,
    output logic [PTR_WIDTH-1:0]  mem_rd_addr_o,
    output logic [PTR_WIDTH:0]    b_rptr_o,
    output logic [PTR_WIDTH:0]    g_rptr_o,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [PTR_WIDTH:0]    rd_level_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i
);

    typedef logic [PTR_WIDTH:0]    ptr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam ptr_t AE_LIMIT = ptr_t'(AE_THRESH);

    function automatic ptr_t bin_to_gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray_to_bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pointer and flag state
    ptr_t  b_rptr_q, b_rptr_d;
    ptr_t  g_rptr_q, g_rptr_d;
    logic  empty_q, empty_d;
    logic  ae_q, ae_d;
    ptr_t  level_q, level_d;

    // Read pipeline and 2-entry output buffer
    logic       inflight_q, inflight_d;
    logic [1:0] buf_cnt_q, buf_cnt_d;
    word_t      head_q, head_d;
    word_t      skid_q, skid_d;

    logic       pop;
    logic       fetch;
    logic       capture;
    logic [1:0] occupancy;
    ptr_t       w_bin;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pop       = 1'b0;
        fetch     = 1'b0;
        capture   = 1'b0;
        occupancy = 2'd0;
        w_bin     = '0;
        b_rptr_d  = b_rptr_q;
        g_rptr_d  = g_rptr_q;
        empty_d   = empty_q;
        ae_d      = ae_q;
        level_d   = level_q;
        inflight_d = 1'b0;

        pop     = (buf_cnt_q != 2'd0) && dout_ready_i;
        capture = inflight_q;

        // Credit: words held plus the one in flight, less the one leaving now, must stay below 2.
        occupancy = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        fetch     = !empty_q && (occupancy < 2'd2);

        b_rptr_d   = b_rptr_q + ptr_t'(fetch);
        g_rptr_d   = bin_to_gray(b_rptr_d);
        inflight_d = fetch;

        // A stale write pointer only lowers the level, so no unwritten word is ever fetched.
        w_bin   = gray_to_bin(g_wptr_sync_i);
        level_d = w_bin - b_rptr_d;
        empty_d = (g_rptr_d == g_wptr_sync_i);
        ae_d    = (level_d <= AE_LIMIT);
    end

    always_comb begin
        head_d    = head_q;
        skid_d    = skid_q;
        buf_cnt_d = buf_cnt_q + {1'b0, capture} - {1'b0, pop};

        case (buf_cnt_q)
            2'd0: begin
                if (capture) head_d = mem_rd_data_i;
            end
            2'd1: begin
                if (capture) begin
                    if (pop) head_d = mem_rd_data_i;
                    else     skid_d = mem_rd_data_i;
                end
            end
            default: begin
                // Full: a capture only arrives here together with a pop.
                if (pop)     head_d = skid_q;
                if (capture) skid_d = mem_rd_data_i;
            end
        endcase
    end

    always_ff @(posedge rd_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rd_rst) begin
            b_rptr_q   <= '0;
            g_rptr_q   <= '0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            level_q    <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            // NOTE: data registers are reset too because dout_o must read zero out of reset.
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            b_rptr_q   <= b_rptr_d;
            g_rptr_q   <= g_rptr_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign mem_rd_en_o    = fetch;
    assign mem_rd_addr_o  = b_rptr_q[PTR_WIDTH-1:0];
    assign b_rptr_o       = b_rptr_q;
    assign g_rptr_o       = g_rptr_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = ae_q;
    assign rd_level_o     = level_q;
    assign dout_o         = head_q;
    assign dout_valid_o   = (buf_cnt_q != 2'd0);

endmodule

// File: tb/tb_rptr_handler_fwft.sv
// Directed bench for rptr_handler_fwft: models the FIFO RAM and writer, scoreboards popped words.
module tb_rptr_handler_fwft;

    localparam int PW = 3;
    localparam int DW = 32;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic [PW:0]   g_wptr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_en;
    logic [PW-1:0] mem_rd_addr;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   rd_level;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    rptr_handler_fwft #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AE_THRESH(1)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .g_wptr_sync_i (g_wptr),
        .mem_rd_data_i (mem_rd_data),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .b_rptr_o      (b_rptr),
        .g_rptr_o      (g_rptr),
        .empty_o       (empty),
        .almost_empty_o(almost_empty),
        .rd_level_o    (rd_level),
        .dout_o        (dout),
        .dout_valid_o  (dout_valid),
        .dout_ready_i  (dout_ready)
    );

    always #5 rd_clk = ~rd_clk;

    // Synchronous-read RAM: data valid one cycle after the strobe.
    logic [DW-1:0] ram [8];
    always @(posedge rd_clk) begin
        if (mem_rd_en === 1'b1) mem_rd_data <= ram[mem_rd_addr];
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [PW:0]   wptr    = '0;
    int            seq     = 0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [PW:0] gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: score any word popped this cycle, then check the Gray pointer moved by at most one bit.
    task automatic tick();
        logic [PW:0] g_prev;
        logic        in_rst;
        in_rst = rd_rst;
        if (!in_rst && dout_valid === 1'b1 && dout_ready) begin
            check("sb_has_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("dout_word", dout, exp_q.pop_front());
        end
        g_prev = g_rptr;
        @(posedge rd_clk);
        #1;
        if (!in_rst) check("gray_step", $countones(g_prev ^ g_rptr) <= 1, 1);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            ram[wptr[PW-1:0]] = {16'hC0DE, seq[15:0]};
            exp_q.push_back({16'hC0DE, seq[15:0]});
            seq++;
            wptr = wptr + 1'b1;
        end
        g_wptr = gray(wptr);
    endtask

    task automatic drain(input string tag);
        int cyc;
        for (cyc = 0; cyc < 64 && !(exp_q.size() == 0 && dout_valid === 1'b0 && empty === 1'b1); cyc++) begin
            tick();
        end
        check({tag, "_in_budget"}, cyc < 64, 1);
        check({tag, "_all_words"}, exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic [PW:0] arb_wptr);
        rd_rst = 1'b1;
        g_wptr = arb_wptr;
        tick();
        exp_q.delete();
        wptr   = '0;
        g_wptr = '0;
        rd_rst = 1'b0;
        check("rst_b_rptr", b_rptr, 0);
        check("rst_g_rptr", g_rptr, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_level", rd_level, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
    endtask

    initial begin
        int nfetch;
        int lvl;
        rd_rst     = 1'b1;
        g_wptr     = '0;
        dout_ready = 1'b1;

        // 1: reset with an arbitrary write pointer
        do_reset(4'b0110);

        // 2: single word
        push_words(1);
        check("t2_empty_before", empty, 1);
        tick();
        check("t2_empty_fell", empty, 0);
        check("t2_level", rd_level, 1);
        check("t2_rd_en", mem_rd_en, 1);
        check("t2_rd_addr", mem_rd_addr, 0);
        check("t2_valid_early", dout_valid, 0);
        tick();
        check("t2_empty_again", empty, 1);
        check("t2_b_rptr", b_rptr, 1);
        check("t2_g_rptr", g_rptr, 1);
        check("t2_rd_en_off", mem_rd_en, 0);
        check("t2_valid_capture", dout_valid, 0);
        tick();
        check("t2_valid", dout_valid, 1);
        check("t2_dout", dout, 32'hC0DE_0000);
        tick();
        check("t2_valid_gone", dout_valid, 0);
        check("t2_b_rptr_end", b_rptr, 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: streaming 8 words with ready held high
        do_reset(4'b1111);
        push_words(8);
        for (int k = 1; k <= 10; k++) begin
            tick();
            lvl = (9 - k > 0) ? 9 - k : 0;
            check($sformatf("t3_level_%0d", k), rd_level, lvl);
            check($sformatf("t3_ae_%0d", k), almost_empty, lvl <= 1);
            check($sformatf("t3_rd_en_%0d", k), mem_rd_en, k <= 8);
            check($sformatf("t3_valid_%0d", k), dout_valid, k >= 3);
        end
        drain("t3");

        // 4: backpressure, only two fetches may be outstanding
        do_reset(4'b0000);
        dout_ready = 1'b0;
        push_words(8);
        nfetch = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_rd_en === 1'b1) nfetch++;
            tick();
        end
        check("t4_fetches", nfetch, 2);
        check("t4_level", rd_level, 6);
        check("t4_valid", dout_valid, 1);
        check("t4_head", dout, 32'hC0DE_0000 + 32'(seq - 8));
        check("t4_empty", empty, 0);
        check("t4_ae", almost_empty, 0);
        tick();
        check("t4_head_stable", dout, exp_q[0]);
        check("t4_no_fetch", mem_rd_en, 0);
        dout_ready = 1'b1;
        drain("t4");

        // 5: three full passes, pointer wraps 15 -> 0
        do_reset(4'b0000);
        for (int p = 0; p < 3; p++) begin
            push_words(8);
            drain($sformatf("t5_pass%0d", p));
            check($sformatf("t5_b_rptr_%0d", p), b_rptr, ((p + 1) * 8) % 16);
            check($sformatf("t5_g_rptr_%0d", p), g_rptr, gray(4'(((p + 1) * 8) % 16)));
            check($sformatf("t5_empty_%0d", p), empty, 1);
            check($sformatf("t5_level_%0d", p), rd_level, 0);
        end

        // 6: reset with a held word and a fetch in flight
        do_reset(4'b0000);
        dout_ready = 1'b0;
        push_words(8);
        tick();
        tick();
        tick();
        check("t6_pre_valid", dout_valid, 1);
        check("t6_pre_level", rd_level, 6);
        do_reset(4'b0101);
        dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_no_stale_%0d", k), dout_valid, 0);
            check($sformatf("t6_no_fetch_%0d", k), mem_rd_en, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
